// File: rtl/mmio_resp_mux.sv
// MMIO response mux: returns one registered response per core request, with error words for unmapped addresses.
// Optional hung-device timeout in WAIT is built when MMIO_TIMEOUT_EN is defined.
module mmio_resp_mux #(
    parameter int unsigned N_INPUTS       = 1,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  rv32_valid,
    input  logic [N_INPUTS-1:0]   dev_sels,
    input  logic [N_INPUTS-1:0]   dev_readys,
    input  logic [N_INPUTS*32-1:0] dev_rdatas,
    output logic                  rv32_ready,
    output logic [31:0]           rv32_rdata,
    output logic                  rv32_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [N_INPUTS-1:0] sel_q, sel_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                ready_q;

    logic [N_INPUTS-1:0] mux_sel;
    logic [31:0]         mux_data;
    logic [31:0]         masked [N_INPUTS];
    logic                timeout;

    // In IDLE the arbiter's live select is used; in WAIT only the latched one counts.
    assign mux_sel = (state_q == IDLE) ? dev_sels : sel_q;

    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_mask
        assign masked[gi] = dev_rdatas[32*gi +: 32] & {32{mux_sel[gi]}};
    end

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            mux_data = mux_data | masked[i];
        end
    end

`ifdef MMIO_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q counts WAIT edges already sampled without a ready.
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == WAIT) begin
            cnt_d = (cnt_q == CNT_W'(TIMEOUT_CYCLES)) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (rv32_valid) begin
                    if (dev_sels == '0) begin
                        rdata_d = ERR_DATA;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if ((dev_sels & dev_readys) != '0) begin
                        rdata_d = mux_data;
                        err_d   = 1'b0;
                        state_d = RESP;
                    end else begin
                        sel_d   = dev_sels;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Abort beats ready, and ready beats timeout.
                if (!rv32_valid) begin
                    state_d = IDLE;
                end else if ((sel_q & dev_readys) != '0) begin
                    rdata_d = mux_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timeout) begin
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            sel_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ready_q <= (state_d == RESP);
        end
    end

    assign rv32_ready = ready_q;
    assign rv32_rdata = rdata_q;
    assign rv32_err   = err_q;

endmodule
